// File: rtl/qnigma_pkg.sv
// Shared types for the qnigma arbitration blocks.
package qnigma_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StGrant
    } arb_state_e;

endpackage

// File: rtl/qnigma_onehot.sv
// Priority select: keeps only the lowest (MSB=0) or highest (MSB=1) set bit of vec_i.
module qnigma_onehot #(
    parameter int unsigned W   = 4,
    parameter bit          MSB = 1'b0
) (
    input  logic [W-1:0] vec_i,
    output logic [W-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (MSB) begin
            for (int i = 0; i < int'(W); i++) begin
                if (vec_i[i]) begin
                    onehot_o    = '0;
                    onehot_o[i] = 1'b1;
                end
            end
        end else begin
            // Scan downwards so the last hit is the lowest set bit
            for (int i = int'(W) - 1; i >= 0; i--) begin
                if (vec_i[i]) begin
                    onehot_o    = '0;
                    onehot_o[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/qnigma_rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant and a bubble between grants.
// Optional grant timeout enabled by defining QNIGMA_ARB_TIMEOUT_EN.
module qnigma_rr_arbiter
    import qnigma_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned TMO_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic                 done,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 vld,
    output logic                 tmo
);

    localparam int unsigned IW = $clog2(N);

    arb_state_e      state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [N-1:0]    mask, oh_masked, oh_raw, sel;
    logic [IW-1:0]   sel_idx, ptr_next;
    logic            rel;

    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            mask[i] = (IW'(i) >= ptr_q);
        end
    end

    qnigma_onehot #(
        .W   (N),
        .MSB (1'b0)
    ) u_onehot_masked (
        .vec_i    (req & mask),
        .onehot_o (oh_masked)
    );

    qnigma_onehot #(
        .W   (N),
        .MSB (1'b0)
    ) u_onehot_raw (
        .vec_i    (req),
        .onehot_o (oh_raw)
    );

    assign sel = (|oh_masked) ? oh_masked : oh_raw;

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (sel[i]) begin
                sel_idx = sel_idx | IW'(i);
            end
        end
    end

    assign ptr_next = (idx_q == IW'(N - 1)) ? '0 : idx_q + IW'(1);

`ifdef QNIGMA_ARB_TIMEOUT_EN
    // Forced release fires on the edge where the counter would reach all-ones
    localparam logic [TMO_W-1:0] TMO_LAST = {TMO_W{1'b1}} - TMO_W'(1);

    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;

    assign cnt_d = (state_q == StGrant) ? cnt_q + TMO_W'(1) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

    assign tmo = tmo_q;
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        rel     = 1'b0;
`ifdef QNIGMA_ARB_TIMEOUT_EN
        tmo_d   = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    state_d = StGrant;
                    gnt_d   = sel;
                    idx_d   = sel_idx;
                end
            end
            StGrant: begin
                rel = done | ~req[idx_q];
`ifdef QNIGMA_ARB_TIMEOUT_EN
                if (!rel && cnt_q == TMO_LAST) begin
                    rel   = 1'b1;
                    tmo_d = 1'b1;
                end
`endif
                if (rel) begin
                    state_d = StIdle;
                    gnt_d   = '0;
                    ptr_d   = ptr_next;
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = idx_q;
    assign vld     = (state_q == StGrant);

endmodule

// File: tb/tb_qnigma_rr_arbiter.sv
// Directed self-checking bench for qnigma_rr_arbiter (N=4, TMO_W=3).
module tb_qnigma_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       vld;
    logic       tmo;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    qnigma_rr_arbiter #(
        .N     (4),
        .TMO_W (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .vld     (vld),
        .tmo     (tmo)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_grant(input string tag, input logic [3:0] g, input logic [1:0] idx,
                               input logic v);
        check({tag, ".gnt"}, 32'(gnt), 32'(g));
        check({tag, ".vld"}, 32'(vld), 32'(v));
        if (v) check({tag, ".idx"}, 32'(gnt_idx), 32'(idx));
    endtask

    // Expected rotation with all requesters active
    logic [3:0] rot [5];

    initial begin
        rot[0] = 4'b0001; rot[1] = 4'b0010; rot[2] = 4'b0100; rot[3] = 4'b1000;
        rot[4] = 4'b0001;

        rst = 1'b1; req = '0; done = 1'b0;
        tick();
        tick();
        check_grant("reset", 4'b0000, 2'd0, 1'b0);
        check("reset.idx", 32'(gnt_idx), 32'd0);
        check("reset.tmo", 32'(tmo), 32'd0);

        // First grant after reset favours index 0 onward
        rst = 1'b0; req = 4'b1010;
        tick();
        check_grant("first", 4'b0010, 2'd1, 1'b1);
        req = 4'b0000;
        tick();
        check_grant("drop_idle", 4'b0000, 2'd1, 1'b0);
        check("idle_idx_hold", 32'(gnt_idx), 32'd1);
        tick();
        check("idle_idx_hold2", 32'(gnt_idx), 32'd1);

        rst = 1'b1;
        tick();
        rst = 1'b0; req = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            check_grant($sformatf("rot%0d", k), rot[k], 2'(k % 4), 1'b1);
            if (k < 4) begin
                done = 1'b1;
                tick();
                check_grant($sformatf("bub%0d", k), 4'b0000, 2'd0, 1'b0);
                done = 1'b0;
                tick();
            end
        end

        // Owner keeps grant while another requester arrives
        req = 4'b0100; done = 1'b1;
        tick();
        check_grant("pre031_bub", 4'b0000, 2'd0, 1'b0);
        done = 1'b0;
        tick();
        check_grant("hold_a", 4'b0100, 2'd2, 1'b1);
        req = 4'b1100;
        tick();
        check_grant("hold_b", 4'b0100, 2'd2, 1'b1);
        tick();
        check_grant("hold_c", 4'b0100, 2'd2, 1'b1);
        req = 4'b1000;
        tick();
        check_grant("drop_bub", 4'b0000, 2'd0, 1'b0);
        tick();
        check_grant("after_drop", 4'b1000, 2'd3, 1'b1);

        // done and req drop together: one release, ptr wraps 3 -> 0
        req = 4'b0011; done = 1'b1;
        tick();
        check_grant("dual_bub", 4'b0000, 2'd0, 1'b0);
        done = 1'b0;
        tick();
        check_grant("dual_next", 4'b0001, 2'd0, 1'b1);

        req = 4'b0000;
        tick();
        req = 4'b0001;
        tick();
        check_grant("lone", 4'b0001, 2'd0, 1'b1);
`ifdef QNIGMA_ARB_TIMEOUT_EN
        for (int k = 0; k < 6; k++) begin
            tick();
            check_grant($sformatf("tmo_hold%0d", k), 4'b0001, 2'd0, 1'b1);
            check($sformatf("tmo_low%0d", k), 32'(tmo), 32'd0);
        end
        tick();
        check_grant("tmo_rel", 4'b0000, 2'd0, 1'b0);
        check("tmo_pulse", 32'(tmo), 32'd1);
        tick();
        check_grant("tmo_regnt", 4'b0001, 2'd0, 1'b1);
        check("tmo_end", 32'(tmo), 32'd0);
`else
        for (int k = 0; k < 12; k++) begin
            tick();
            check_grant($sformatf("nt_hold%0d", k), 4'b0001, 2'd0, 1'b1);
            check($sformatf("nt_tmo%0d", k), 32'(tmo), 32'd0);
        end
`endif

        // Move ptr off zero, then reset mid-grant
        req = 4'b1000;
        tick();
        tick();
        check_grant("pre_rst", 4'b1000, 2'd3, 1'b1);
        rst = 1'b1;
        tick();
        check_grant("mid_rst", 4'b0000, 2'd0, 1'b0);
        check("mid_rst.tmo", 32'(tmo), 32'd0);
        check("mid_rst.idx", 32'(gnt_idx), 32'd0);
        rst = 1'b0; req = 4'b1001;
        tick();
        check_grant("post_rst", 4'b0001, 2'd0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Grant must be one-hot or zero on every cycle
    always @(negedge clk) begin
        if (!rst && $countones(gnt) > 1) begin
            check("onehot", 32'(gnt), 32'(0));
        end
    end

endmodule

// File: doc/qnigma_rr_arbiter.md
QNIGMA_RR_ARBITER -- requirements
Module: qnigma_rr_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 4, number of requesters (N >= 2).
REQ-002 The block SHALL have parameter TMO_W, default 8, timeout counter width.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port req  input  N  request vector, one bit per requester.
REQ-006 The block SHALL have port done  input  1  the current owner releases its grant.
REQ-007 The block SHALL have port gnt  output  N  registered one-hot grant, all zeros when idle.
REQ-008 The block SHALL have port gnt_idx  output  $clog2(N)  binary index of the granted requester.
REQ-009 The block SHALL have port vld  output  1  high while any grant is held.
REQ-010 The block SHALL have port tmo  output  1  one-cycle pulse on a forced release.

Function
REQ-011 The state machine SHALL have two states: IDLE and GRANT.
REQ-012 In IDLE with req != 0, the next cycle SHALL enter GRANT; gnt SHALL select the lowest-index req bit at or above pointer ptr, else the lowest-index req bit overall (wrap); latency SHALL be 1 cycle.
REQ-013 In IDLE with req == 0, the outputs SHALL stay at gnt=0, vld=0 and gnt_idx unchanged.
REQ-014 In GRANT, gnt, gnt_idx and vld=1 SHALL hold while req[gnt_idx]=1 and done=0, regardless of other req bits.
REQ-015 A release SHALL occur in GRANT when done=1, or req[gnt_idx]=0, or both in the same cycle; a simultaneous drop and done SHALL count as one release.
REQ-016 On release, the next cycle SHALL be IDLE with gnt=0 and vld=0; ptr SHALL become (gnt_idx+1) mod N; one bubble cycle SHALL separate consecutive grants.
REQ-017 done SHALL be ignored in IDLE.
REQ-018 gnt SHALL never have more than one bit set, and gnt_idx SHALL always equal the encoding of gnt while vld=1.

Reset
REQ-019 While rst=1, the block SHALL hold state=IDLE, gnt=0, gnt_idx=0, vld=0, tmo=0, ptr=0, and timeout counter=0.
REQ-020 rst asserted mid-GRANT SHALL drop the grant on the following edge without a tmo pulse.
REQ-021 The first arbitration after reset SHALL favour index 0.

Configuration
REQ-022 With macro QNIGMA_ARB_TIMEOUT_EN defined, a TMO_W-bit counter SHALL clear on GRANT entry and increment on each GRANT cycle.
REQ-023 With QNIGMA_ARB_TIMEOUT_EN defined, when the counter reaches 2^TMO_W-1 without a release, the block SHALL force a release (REQ-016 behaviour) and pulse tmo for exactly 1 cycle, aligned with gnt clearing.
REQ-024 With QNIGMA_ARB_TIMEOUT_EN defined, a normal release in the same cycle as expiry SHALL take precedence, and no tmo pulse SHALL be produced.
REQ-025 Without QNIGMA_ARB_TIMEOUT_EN, no counter SHALL be built, tmo SHALL be tied 0, and grants SHALL be held indefinitely.

Structure
REQ-026 The arbiter state enum (IDLE, GRANT) SHALL live in the shared qnigma package.
REQ-027 Lowest-index selection SHALL be done by instantiating qnigma_onehot (MSB=0) twice: once on req masked by ptr, once on unmasked req.
REQ-028 One-hot to binary conversion for gnt_idx SHALL be done in-module; no other sub-modules SHALL be used.

Verification
REQ-029 Reset then req=4'b1010 -> one cycle later gnt=4'b0010, gnt_idx=1, vld=1.
REQ-030 Hold req=4'b1111 and pulse done each grant -> grants SHALL go 0001, 0010, 0100, 1000, 0001, with one idle cycle between each.
REQ-031 While granted 4'b0100, assert req[3] and then drop req[2] -> gnt SHALL hold 0100 until the drop; then 1 idle cycle; then gnt=1000.
REQ-032 While granted, assert done and drop the owner's req in the same cycle -> exactly one release, and ptr SHALL advance by exactly one.
REQ-033 QNIGMA_ARB_TIMEOUT_EN with TMO_W=3, req=4'b0001 held and done=0 -> forced release after 7 GRANT cycles, tmo=1 for 1 cycle, then re-grant 0001 after the bubble.
REQ-034 Assert rst mid-GRANT -> next cycle gnt=0, vld=0, tmo=0; next grant from req=4'b1001 SHALL be 0001.
